// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
//   NREQ requesters compete for write access; the winner's data word is captured
//   into q and the winner gets a one-cycle ack. This block is the only writer of q.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   req      in   [NREQ]        request per requester
//   data_in  in   [NREQ*WIDTH]  requester i owns bits [i*WIDTH +: WIDTH]
//   grant    out  [NREQ]        one-hot current owner, zero when idle
//   ack      out  [NREQ]        one-cycle one-hot pulse, owner's write complete
//   q        out  [WIDTH]       shared register contents
//   q_valid  out                one-cycle pulse coincident with the q update
//   q_owner  out  [$clog2(NREQ)] index of the requester that last wrote q
//   busy     out                high whenever the sequencer is not idle
//
// state | meaning
// IDLE  | no transfer in flight; arbitrate on any pending req
// GRANT | winner holds grant; q captures its data on the next edge
// ACK   | ack/q_valid pulse visible; pointer advances to the winner
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data_in,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          ack,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(NREQ)-1:0]  q_owner,
  output logic                     busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [PW-1:0]     win, win_nxt;
  logic [NREQ-1:0]   grant_nxt, ack_nxt;
  logic [WIDTH-1:0]  q_nxt;
  logic              q_valid_nxt, busy_nxt;
  logic [PW-1:0]     q_owner_nxt;

  logic              found;
  logic [PW-1:0]     sel;
  logic [PW:0]       sum;

  // Search ptr+1, ptr+2, ... modulo NREQ; the first set request wins. Starting
  // one past the last winner is what makes a re-requesting owner lose to others.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        sel   = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_nxt     = win;
    grant_nxt   = grant;
    ack_nxt     = '0;
    q_nxt       = q;
    q_valid_nxt = 1'b0;
    q_owner_nxt = q_owner;
    busy_nxt    = busy;
    case (state)
      IDLE: begin
        if (found) begin
          win_nxt        = sel;
          grant_nxt      = '0;
          grant_nxt[sel] = 1'b1;
          busy_nxt       = 1'b1;
          state_nxt      = GRANT;
        end
      end
      GRANT: begin
        // req is deliberately not rechecked: a withdrawn request still completes.
        q_nxt       = data_in[int'(win)*WIDTH +: WIDTH];
        q_owner_nxt = win;
        q_valid_nxt = 1'b1;
        ack_nxt     = grant;
        state_nxt   = ACK;
      end
      ACK: begin
        grant_nxt = '0;
        ptr_nxt   = win;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= PW'(NREQ-1);
      win     <= '0;
      grant   <= '0;
      ack     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      q_owner <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win     <= win_nxt;
      grant   <= grant_nxt;
      ack     <= ack_nxt;
      q       <= q_nxt;
      q_valid <= q_valid_nxt;
      q_owner <= q_owner_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule
